// File: rtl/super_pkg.sv
// Shared types and pointer helpers for the load/store write-back tracker.
package super_pkg;

  localparam int WbDataW = 65;

  // The data field is sized for the widest payload in use; the tracker's DataW must not exceed WbDataW.
  typedef struct packed {
    logic [4:0]         rd;
    logic               we;
    logic               err;
    logic               wrsv;
    logic [WbDataW-1:0] data;
  } wb_entry_t;

  // Pointers carry one wrap bit above aw index bits.
  function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                    input int unsigned aw);
    return (wr ^ rd) == (32'd1 << aw);
  endfunction

  function automatic logic [31:0] ptr_count(input logic [31:0] wr, input logic [31:0] rd,
                                            input int unsigned pw);
    return (wr - rd) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/ls_wb_waw_cam.sv
// Compares each entry's rd against the WAW kill ports and flags which reservations to clear.
module ls_wb_waw_cam #(
  parameter int Depth  = 8,
  parameter int NumWaw = 2
) (
  input  logic [Depth*5-1:0]  ent_rd_i,
  input  logic [Depth-1:0]    ent_vld_i,
  input  logic                waw_valid_i,
  input  logic [NumWaw*5-1:0] waw_rd_i,
  output logic [Depth-1:0]    clr_o
);

  always_comb begin
    clr_o = '0;
    for (int i = 0; i < Depth; i++) begin
      for (int k = 0; k < NumWaw; k++) begin
        if (waw_valid_i && ent_vld_i[i] && (ent_rd_i[i*5 +: 5] == waw_rd_i[k*5 +: 5]))
          clr_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ls_wb_tracker.sv
// Unified write-back buffer and WAW-reservation tracker for the load/store pipeline.
// Define LS_WB_BYPASS_EN to present a response on out_* in the same cycle when the buffer head is waiting on it.
module ls_wb_tracker
  import super_pkg::*;
#(
  parameter int Depth  = 8,
  parameter int DataW  = 65,
  parameter int NumWaw = 2,
  parameter int AfThr  = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alloc_valid_i,
  input  logic [4:0]                 alloc_rd_i,
  output logic                       alloc_rdy_o,
  input  logic                       resp_valid_i,
  input  logic                       resp_we_i,
  input  logic                       resp_err_i,
  input  logic [4:0]                 resp_rd_i,
  input  logic [DataW-1:0]           resp_data_i,
  output logic                       resp_af_o,
  input  logic                       waw_valid_i,
  input  logic [NumWaw*5-1:0]        waw_rd_i,
  output logic                       out_valid_o,
  input  logic                       out_rdy_i,
  output logic [DataW-1:0]           out_data_o,
  output logic [4:0]                 out_waddr_o,
  output logic                       out_we_o,
  output logic                       out_wrsv_o,
  output logic                       out_err_o,
  output logic                       err_active_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int AW   = $clog2(Depth);
  localparam int PtrW = AW + 1;
  localparam logic [PtrW-1:0] DepthM2 = PtrW'(Depth - 2);
  localparam logic [PtrW-1:0] AfThrP  = PtrW'(AfThr);

  wb_entry_t         ent_q [Depth];
  logic [PtrW-1:0]   wr_q, fill_q, rd_q, count;
  logic              err_q;
  logic              full, self_alloc, alloc_fire, drain, alloc_hit, head_wrsv;
  logic [AW-1:0]     rd_idx, fill_idx, alloc_idx;
  logic [Depth-1:0]  ent_vld, waw_clr;
  logic [Depth*5-1:0] ent_rd;
  wb_entry_t         head;

  assign rd_idx     = rd_q[AW-1:0];
  assign fill_idx   = fill_q[AW-1:0];
  assign count      = PtrW'(ptr_count(32'(wr_q), 32'(rd_q), PtrW));
  assign full       = ptr_full(32'(wr_q), 32'(rd_q), AW);
  assign self_alloc = resp_valid_i & (fill_q == wr_q);
  // A self-allocating response claims slot wr, so a same-cycle allocation lands one slot later.
  assign alloc_idx  = wr_q[AW-1:0] + AW'(self_alloc);
  assign head       = ent_q[rd_idx];

  assign err_active_o = err_q | (resp_valid_i & resp_err_i);
  assign alloc_rdy_o  = ~err_active_o & (self_alloc ? (count <= DepthM2) : ~full);
  assign alloc_fire   = alloc_valid_i & alloc_rdy_o;
  assign resp_af_o    = (count >= AfThrP);
  assign count_o      = count;
  assign drain        = out_valid_o & out_rdy_i;

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      ent_rd[i*5 +: 5] = ent_q[i].rd;
      ent_vld[i]       = ({1'b0, AW'(i) - rd_idx} < count) & ent_q[i].wrsv;
    end
  end

  always_comb begin
    alloc_hit = 1'b0;
    for (int k = 0; k < NumWaw; k++) begin
      if (waw_valid_i && (waw_rd_i[k*5 +: 5] == alloc_rd_i)) alloc_hit = 1'b1;
    end
  end

  ls_wb_waw_cam #(.Depth(Depth), .NumWaw(NumWaw)) u_waw_cam (
    .ent_rd_i    (ent_rd),
    .ent_vld_i   (ent_vld),
    .waw_valid_i (waw_valid_i),
    .waw_rd_i    (waw_rd_i),
    .clr_o       (waw_clr)
  );

  always_comb begin
    out_valid_o = (rd_q != fill_q);
    out_data_o  = DataW'(head.data);
    out_waddr_o = head.rd;
    out_we_o    = head.we;
    out_err_o   = head.err;
    head_wrsv   = head.wrsv;
`ifdef LS_WB_BYPASS_EN
    if (resp_valid_i && (rd_q == fill_q)) begin
      out_valid_o = 1'b1;
      out_data_o  = resp_data_i;
      out_we_o    = resp_we_i;
      out_err_o   = resp_err_i;
      out_waddr_o = self_alloc ? resp_rd_i : head.rd;
      head_wrsv   = ~self_alloc & head.wrsv & ~waw_clr[rd_idx];
    end
`endif
    out_wrsv_o = out_we_o & head_wrsv;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q   <= '0;
      fill_q <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < Depth; i++) ent_q[i].wrsv <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (waw_clr[i]) ent_q[i].wrsv <= 1'b0;
      end
      if (resp_valid_i) begin
        ent_q[fill_idx].data <= WbDataW'(resp_data_i);
        ent_q[fill_idx].we   <= resp_we_i;
        ent_q[fill_idx].err  <= resp_err_i;
        if (self_alloc) begin
          ent_q[fill_idx].rd   <= resp_rd_i;
          ent_q[fill_idx].wrsv <= 1'b0;
        end
      end
      if (alloc_fire) begin
        ent_q[alloc_idx].rd   <= alloc_rd_i;
        ent_q[alloc_idx].wrsv <= ~alloc_hit;
      end
      fill_q <= fill_q + PtrW'(resp_valid_i);
      wr_q   <= wr_q + PtrW'(self_alloc) + PtrW'(alloc_fire);
      rd_q   <= rd_q + PtrW'(drain);
      if (resp_valid_i && resp_err_i) err_q <= 1'b1;
    end
  end

  // A response with no pending allocation and no free slot has nowhere to go.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) assert (!(resp_valid_i && full && (fill_q == wr_q)));
  end

endmodule

// File: tb/tb_ls_wb_tracker.sv
// Directed self-checking bench for ls_wb_tracker (Depth=8, DataW=65, NumWaw=2, AfThr=6).
module tb_ls_wb_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        alloc_valid_i, alloc_rdy_o;
  logic [4:0]  alloc_rd_i;
  logic        resp_valid_i, resp_we_i, resp_err_i, resp_af_o;
  logic [4:0]  resp_rd_i;
  logic [64:0] resp_data_i;
  logic        waw_valid_i;
  logic [9:0]  waw_rd_i;
  logic        out_valid_o, out_rdy_i, out_we_o, out_wrsv_o, out_err_o, err_active_o;
  logic [64:0] out_data_o;
  logic [4:0]  out_waddr_o;
  logic [3:0]  count_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ls_wb_tracker #(.Depth(8), .DataW(65), .NumWaw(2), .AfThr(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_rd_i(alloc_rd_i), .alloc_rdy_o(alloc_rdy_o),
    .resp_valid_i(resp_valid_i), .resp_we_i(resp_we_i), .resp_err_i(resp_err_i),
    .resp_rd_i(resp_rd_i), .resp_data_i(resp_data_i), .resp_af_o(resp_af_o),
    .waw_valid_i(waw_valid_i), .waw_rd_i(waw_rd_i),
    .out_valid_o(out_valid_o), .out_rdy_i(out_rdy_i), .out_data_o(out_data_o),
    .out_waddr_o(out_waddr_o), .out_we_o(out_we_o), .out_wrsv_o(out_wrsv_o),
    .out_err_o(out_err_o), .err_active_o(err_active_o), .count_o(count_o)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [4:0] r);
    alloc_valid_i = 1'b1;
    alloc_rd_i    = r;
    step();
    alloc_valid_i = 1'b0;
  endtask

  task automatic resp(input logic [64:0] d, input logic [4:0] r, input logic we, input logic err);
    resp_valid_i = 1'b1;
    resp_data_i  = d;
    resp_rd_i    = r;
    resp_we_i    = we;
    resp_err_i   = err;
    step();
    resp_valid_i = 1'b0;
    resp_err_i   = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    alloc_valid_i = 1'b0; alloc_rd_i = '0;
    resp_valid_i = 1'b0; resp_we_i = 1'b0; resp_err_i = 1'b0; resp_rd_i = '0; resp_data_i = '0;
    waw_valid_i = 1'b0; waw_rd_i = '0; out_rdy_i = 1'b0;
    step(); step();
    check("rst_valid", out_valid_o, 0);
    check("rst_rdy", alloc_rdy_o, 1);
    check("rst_af", resp_af_o, 0);
    check("rst_count", count_o, 0);
    check("rst_err", err_active_o, 0);
    rst_i = 1'b0;

    // in-order allocate then fill
    alloc(5'd5);
    alloc(5'd7);
    check("t1_count", count_o, 2);
    check("t1_pending", out_valid_o, 0);
    resp_valid_i = 1'b1; resp_data_i = 65'hAA; resp_we_i = 1'b1; resp_rd_i = 5'd0;
`ifndef LS_WB_BYPASS_EN
    #1 check("t1_latency", out_valid_o, 0);
`endif
    step();
    resp_data_i = 65'hBB; out_rdy_i = 1'b1;
    check("t1_v0", out_valid_o, 1);
    check("t1_a0", out_waddr_o, 5);
    check("t1_d0", out_data_o, 65'hAA);
    check("t1_r0", out_wrsv_o, 1);
    step();
    resp_valid_i = 1'b0;
    check("t1_v1", out_valid_o, 1);
    check("t1_a1", out_waddr_o, 7);
    check("t1_d1", out_data_o, 65'hBB);
    check("t1_r1", out_wrsv_o, 1);
    step();
    out_rdy_i = 1'b0;
    check("t1_empty", count_o, 0);

    // WAW kill on a pending entry
    alloc(5'd5);
    waw_valid_i = 1'b1; waw_rd_i = {5'd5, 5'd0};
    step();
    waw_valid_i = 1'b0;
    resp(65'h1C, 5'd0, 1'b1, 1'b0);
    check("t2_valid", out_valid_o, 1);
    check("t2_waddr", out_waddr_o, 5);
    check("t2_wrsv", out_wrsv_o, 0);
    out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;

    // same-cycle self-allocation plus allocation
    resp_valid_i = 1'b1; resp_data_i = 65'h99; resp_rd_i = 5'd9; resp_we_i = 1'b1;
    alloc_valid_i = 1'b1; alloc_rd_i = 5'd3;
    #1 check("t3_rdy", alloc_rdy_o, 1);
    step();
    resp_valid_i = 1'b0; alloc_valid_i = 1'b0;
    check("t3_count", count_o, 2);
    check("t3_waddr", out_waddr_o, 9);
    check("t3_wrsv", out_wrsv_o, 0);
    check("t3_data", out_data_o, 65'h99);
    out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;
    check("t3_count1", count_o, 1);
    check("t3_pend", out_valid_o, 0);
    resp(65'h33, 5'd0, 1'b1, 1'b0);
    check("t3_waddr2", out_waddr_o, 3);
    check("t3_wrsv2", out_wrsv_o, 1);
    out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;

    // almost-full, full, and in-order drain
    for (int i = 0; i < 5; i++) alloc(5'(i + 1));
    check("t4_af5", resp_af_o, 0);
    alloc(5'd6);
    check("t4_af6", resp_af_o, 1);
    check("t4_count6", count_o, 6);
    alloc(5'd7);
    alloc(5'd8);
    check("t4_full_rdy", alloc_rdy_o, 0);
    alloc(5'd20);
    check("t4_ignored", count_o, 8);
    for (int i = 0; i < 8; i++) resp(65'h100 + 65'(i), 5'd0, 1'b1, 1'b0);
    out_rdy_i = 1'b1;
    check("t4_head", out_data_o, 65'h100);
    step();
    out_rdy_i = 1'b0;
    check("t4_rdy", alloc_rdy_o, 1);
    check("t4_count7", count_o, 7);
    out_rdy_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("t4_dord", out_data_o, 65'h100 + 65'(i));
      check("t4_aord", out_waddr_o, 80'(i + 1));
      step();
    end
    out_rdy_i = 1'b0;
    check("t4_drained", count_o, 0);

    // stream through the buffer enough to wrap the pointers repeatedly
    for (int j = 0; j < 32; j++) begin
      alloc(5'(j));
      resp(65'hD000 + 65'(j), 5'd0, 1'b1, 1'b0);
      check("wrap_data", out_data_o, 65'hD000 + 65'(j));
      check("wrap_addr", out_waddr_o, 80'(j % 32));
      out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;
    end
    check("wrap_empty", count_o, 0);

    // sticky error and flush
    resp_valid_i = 1'b1; resp_err_i = 1'b1; resp_we_i = 1'b0; resp_rd_i = 5'd4; resp_data_i = 65'h0;
    #1 check("t5_err_now", err_active_o, 1);
    check("t5_rdy_now", alloc_rdy_o, 0);
    step();
    resp_valid_i = 1'b0; resp_err_i = 1'b0;
    check("t5_sticky", err_active_o, 1);
    check("t5_rdy", alloc_rdy_o, 0);
    check("t5_out_err", out_err_o, 1);
    check("t5_valid", out_valid_o, 1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("t5_count", count_o, 0);
    check("t5_err_clr", err_active_o, 0);
    check("t5_rdy_back", alloc_rdy_o, 1);

    // reset mid-operation
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    resp(65'h11, 5'd0, 1'b1, 1'b0);
    resp(65'h22, 5'd0, 1'b1, 1'b1);
    check("t6_count4", count_o, 4);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    check("t6_valid", out_valid_o, 0);
    check("t6_rdy", alloc_rdy_o, 1);
    check("t6_af", resp_af_o, 0);
    check("t6_count", count_o, 0);
    check("t6_err", err_active_o, 0);

    // response to an empty buffer with commit ready
    resp_valid_i = 1'b1; resp_data_i = 65'h77; resp_rd_i = 5'd11; resp_we_i = 1'b1;
    out_rdy_i = 1'b1;
`ifdef LS_WB_BYPASS_EN
    #1 check("byp_valid", out_valid_o, 1);
    check("byp_data", out_data_o, 65'h77);
    check("byp_waddr", out_waddr_o, 11);
    check("byp_wrsv", out_wrsv_o, 0);
    step();
    resp_valid_i = 1'b0;
    check("byp_count", count_o, 0);
    check("byp_after", out_valid_o, 0);
`else
    #1 check("nobyp_valid", out_valid_o, 0);
    step();
    resp_valid_i = 1'b0;
    check("nobyp_valid1", out_valid_o, 1);
    check("nobyp_data", out_data_o, 65'h77);
    check("nobyp_waddr", out_waddr_o, 11);
    step();
    check("nobyp_count", count_o, 0);
`endif
    out_rdy_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
